// File: rtl/product_collector_pkg.sv
// Shared types for the product collector: FSM state and result record.
package product_collector_pkg;

    localparam int MAX_SUM_W = 32;
    localparam int MAX_CNT_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Record fields are sized for the largest supported ACC_WIDTH/WINDOW.
    typedef struct packed {
        logic [MAX_SUM_W-1:0] sum;
        logic [MAX_CNT_W-1:0] count;
        logic                 ovf;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

endpackage

// File: rtl/product_collector_result_fifo.sv
// Two-entry result buffer; head entry is always presented on o_data.
module result_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_occ;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_occ == 2'd2);
    assign o_empty = (r_occ == 2'd0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/product_collector.sv
// Collects unsigned product samples into fixed windows and emits
// saturated window sums through a two-entry result buffer.
module product_collector
    import product_collector_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8,
    parameter int WINDOW    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_sum,
    output logic [$clog2(WINDOW+1)-1:0]  out_count,
    output logic                         out_ovf
);

    localparam int CW = $clog2(WINDOW+1);

    state_e               r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_ovf;

    logic                 w_accept;
    logic [ACC_WIDTH:0]   w_sum_ext;
    logic                 w_sat;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_ovf_nxt;
    logic                 w_win_full;
    logic                 w_close;
    logic                 w_full;
    logic                 w_empty;
    result_t              w_push_rec;
    result_t              w_head;
    logic                 w_unused_head;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_accept  = in_valid && in_ready;

    // One extra bit catches the carry that signals saturation.
    assign w_sum_ext = {1'b0, r_acc} + (ACC_WIDTH+1)'(in_data);
    assign w_sat     = w_sum_ext[ACC_WIDTH];

    assign w_acc_nxt = !w_accept ? r_acc :
                       w_sat     ? '1    : w_sum_ext[ACC_WIDTH-1:0];
    assign w_cnt_nxt = w_accept ? r_cnt + 1'b1 : r_cnt;
    assign w_ovf_nxt = r_ovf | (w_accept & w_sat);

    assign w_win_full = w_accept && (w_cnt_nxt == CW'(WINDOW));
    // Flush waits while the buffer is full; an open window or a
    // same-cycle sample is needed so no empty record is produced.
    assign w_close = in_ready && (w_win_full ||
                     (flush && (r_state == ST_ACCUM || w_accept)));

    always_comb begin
        w_push_rec                     = '0;
        w_push_rec.sum[ACC_WIDTH-1:0]  = w_acc_nxt;
        w_push_rec.count[CW-1:0]       = w_cnt_nxt;
        w_push_rec.ovf                 = w_ovf_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_close) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_state <= ST_ACCUM;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    result_fifo #(
        .DW (RESULT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_close),
        .i_data  (w_push_rec),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_sum       = w_head.sum[ACC_WIDTH-1:0];
    assign out_count     = w_head.count[CW-1:0];
    assign out_ovf       = w_head.ovf;
    assign w_unused_head = ^w_head;

endmodule

// File: tb/tb_product_collector.sv
// Bench for product_collector: directed table, corner sequences and
// randomized traffic against a window/queue reference model.
module tb_product_collector;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       flush;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_ovf_a;
    logic [7:0] out_sum_a;
    logic [2:0] out_count_a;
    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [4:0] out_sum_b;
    logic [2:0] out_count_b;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;

    product_collector u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
        .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
    );

    product_collector #(.WIDTH(4), .ACC_WIDTH(5), .WINDOW(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: true (unsaturated) window total and sample count,
    // plus a queue of closed windows awaiting the consumer.
    typedef struct { int tot; int n; } rec_t;
    rec_t q[$];
    int   m_tot;
    int   m_n;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int capped(input int tot, input int cap);
        return (tot > cap) ? cap : tot;
    endfunction

    task automatic model_check();
        chk("ready_a", int'(in_ready_a), int'(q.size() < 2));
        chk("ready_b", int'(in_ready_b), int'(q.size() < 2));
        chk("valid_a", int'(out_valid_a), int'(q.size() > 0));
        chk("valid_b", int'(out_valid_b), int'(q.size() > 0));
        if (q.size() > 0) begin
            chk("sum_a", int'(out_sum_a), capped(q[0].tot, 255));
            chk("cnt_a", int'(out_count_a), q[0].n);
            chk("ovf_a", int'(out_ovf_a), int'(q[0].tot > 255));
            chk("sum_b", int'(out_sum_b), capped(q[0].tot, 31));
            chk("cnt_b", int'(out_count_b), q[0].n);
            chk("ovf_b", int'(out_ovf_b), int'(q[0].tot > 31));
        end
    endtask

    task automatic step(input bit v, input int d, input bit f,
                        input bit ordy, input bit rst, output bit acc);
        bit rdy, pop, cls;
        int ntot, nn;
        in_valid  = v;
        in_data   = 4'(d);
        flush     = f;
        out_ready = ordy;
        reset     = rst;
        model_check();
        if (!rst && out_valid_a && ordy) n_pop++;
        @(posedge clk);
        rdy  = (q.size() < 2);
        acc  = v && rdy && !rst;
        pop  = (q.size() > 0) && ordy;
        ntot = m_tot + (acc ? d : 0);
        nn   = m_n + (acc ? 1 : 0);
        cls  = rdy && ((acc && nn == 4) || (f && nn > 0));
        if (rst) begin
            q.delete();
            m_tot = 0;
            m_n   = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (cls) begin
                q.push_back('{tot: ntot, n: nn});
                m_tot = 0;
                m_n   = 0;
            end else begin
                m_tot = ntot;
                m_n   = nn;
            end
        end
        #1;
    endtask

    typedef struct { bit v; int d; bit f; bit ev; int es; int ec; } vec_t;
    vec_t tbl[15];

    initial begin
        bit a;
        int sent, cyc;

        tbl[0]  = '{1, 1, 0, 0,  0, 0};
        tbl[1]  = '{1, 2, 0, 0,  0, 0};
        tbl[2]  = '{1, 3, 0, 0,  0, 0};
        tbl[3]  = '{1, 4, 0, 0,  0, 0};
        tbl[4]  = '{0, 0, 0, 1, 10, 4};
        tbl[5]  = '{1, 5, 0, 0,  0, 0};
        tbl[6]  = '{1, 6, 0, 0,  0, 0};
        tbl[7]  = '{0, 0, 1, 0,  0, 0};
        tbl[8]  = '{0, 0, 0, 1, 11, 2};
        tbl[9]  = '{1, 5, 0, 0,  0, 0};
        tbl[10] = '{1, 7, 1, 0,  0, 0};
        tbl[11] = '{0, 0, 0, 1, 12, 2};
        tbl[12] = '{0, 0, 1, 0,  0, 0};
        tbl[13] = '{0, 0, 0, 0,  0, 0};
        tbl[14] = '{0, 0, 0, 0,  0, 0};

        m_tot = 0;
        m_n   = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'd0;
        flush    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_valid", int'(out_valid_a), 0);
        chk("rst_ready", int'(in_ready_a), 1);
        chk("rst_sum", int'(out_sum_a), 0);
        chk("rst_count", int'(out_count_a), 0);
        chk("rst_ovf", int'(out_ovf_a), 0);
        chk("rst_ready_b", int'(in_ready_b), 1);

        for (int i = 0; i < 15; i++) begin
            in_valid = tbl[i].v;
            in_data  = 4'(tbl[i].d);
            flush    = tbl[i].f;
            chk($sformatf("tbl%0d_ready", i), int'(in_ready_a), 1);
            chk($sformatf("tbl%0d_valid", i), int'(out_valid_a),
                int'(tbl[i].ev));
            chk($sformatf("tbl%0d_valid_b", i), int'(out_valid_b),
                int'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_sum", i), int'(out_sum_a), tbl[i].es);
                chk($sformatf("tbl%0d_cnt", i), int'(out_count_a),
                    tbl[i].ec);
                chk($sformatf("tbl%0d_ovf", i), int'(out_ovf_a), 0);
                chk($sformatf("tbl%0d_sum_b", i), int'(out_sum_b),
                    tbl[i].es);
            end
            @(posedge clk);
            #1;
        end

        // Saturation on the narrow accumulator, then a clean window.
        step(0, 0, 0, 1, 1, a);
        for (int i = 0; i < 4; i++) step(1, 15, 0, 1, 0, a);
        chk("sat_sum_b", int'(out_sum_b), 31);
        chk("sat_cnt_b", int'(out_count_b), 4);
        chk("sat_ovf_b", int'(out_ovf_b), 1);
        chk("sat_sum_a", int'(out_sum_a), 60);
        chk("sat_ovf_a", int'(out_ovf_a), 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, a);
        chk("post_sat_sum_b", int'(out_sum_b), 4);
        chk("post_sat_ovf_b", int'(out_ovf_b), 0);

        // Backpressure: 12 samples of 1 with the consumer stalled first.
        step(0, 0, 0, 0, 1, a);
        n_pop = 0;
        sent  = 0;
        cyc   = 0;
        while (sent < 12 && cyc < 100) begin
            if (cyc == 8) begin
                chk("stall_ready", int'(in_ready_a), 0);
                chk("stall_sum", int'(out_sum_a), 4);
            end
            if (cyc == 11) chk("stall_hold_sum", int'(out_sum_a), 4);
            step(1, 1, 0, cyc >= 12, 0, a);
            if (a) sent++;
            cyc++;
        end
        chk("bp_sent", sent, 12);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, a);
        chk("bp_pops", n_pop, 3);

        // Reset in the middle of an open window.
        step(0, 0, 0, 1, 1, a);
        step(1, 3, 0, 1, 0, a);
        step(1, 3, 0, 1, 0, a);
        step(0, 0, 0, 1, 1, a);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, a);
        chk("mid_rst_valid", int'(out_valid_a), 1);
        chk("mid_rst_sum", int'(out_sum_a), 4);
        chk("mid_rst_cnt", int'(out_count_a), 4);
        step(0, 0, 0, 1, 0, a);
        chk("mid_rst_single", int'(out_valid_a), 0);

        // Push and pop in the same cycle at occupancy 1.
        step(0, 0, 0, 0, 1, a);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, a);
        for (int i = 0; i < 3; i++) step(1, 2, 0, 0, 0, a);
        chk("pp_head1", int'(out_sum_a), 4);
        step(1, 2, 0, 1, 0, a);
        chk("pp_ready", int'(in_ready_a), 1);
        chk("pp_valid", int'(out_valid_a), 1);
        chk("pp_head2", int'(out_sum_a), 8);
        step(0, 0, 0, 1, 0, a);
        chk("pp_empty", int'(out_valid_a), 0);

        // Randomized traffic.
        step(0, 0, 0, 1, 1, a);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 99) == 0, a);
        end
        model_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
